// File: rtl/chip_7458_tester.sv
// Exhaustive 1024-vector sweep driver and response checker for a 7458 dual AND-OR chip.
// Optional first-failure capture is built only when CHIP7458_FAIL_CAPTURE_EN is defined.
module chip_7458_tester #(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_CNT_W     = 11
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 stop_on_fail,
    output logic                 p1a,
    output logic                 p1b,
    output logic                 p1c,
    output logic                 p1d,
    output logic                 p1e,
    output logic                 p1f,
    output logic                 p2a,
    output logic                 p2b,
    output logic                 p2c,
    output logic                 p2d,
    input  logic                 p1y,
    input  logic                 p2y,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 fail_valid,
    output logic [9:0]           fail_vec,
    output logic [1:0]           fail_y
);

    localparam int         CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int         CNT_INIT = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
    localparam logic [9:0] LAST_VEC = 10'd1023;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [9:0]       vec;
    logic [9:0]       pins;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       exp_y;
    logic [1:0]       obs_y;
    logic             mismatch;
    logic             launch;

    always_comb begin
        exp_y[1] = (vec[9] & vec[8] & vec[7]) | (vec[6] & vec[5] & vec[4]);
        exp_y[0] = (vec[3] & vec[2]) | (vec[1] & vec[0]);
    end

    assign obs_y    = {p1y, p2y};
    assign mismatch = (state == CHECK) && (obs_y != exp_y);
    assign launch   = ((state == IDLE) || (state == DONE)) && start;

    always_comb begin
        // NOTE: default assigned first so every path drives state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = DRIVE;
            DRIVE:      state_nxt = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
            SETTLE:     if (cnt == '0) state_nxt = CHECK;
            CHECK: begin
                if ((mismatch && stop_on_fail) || (vec == LAST_VEC)) state_nxt = DONE;
                else                                                  state_nxt = DRIVE;
            end
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the pre-edge values.
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            vec       <= '0;
            pins      <= '0;
            cnt       <= '0;
            err_count <= '0;
        end else if (launch) begin
            vec       <= '0;
            err_count <= '0;
        end else begin
            case (state)
                DRIVE: begin
                    pins <= vec;
                    cnt  <= CNT_W'(CNT_INIT);
                end
                SETTLE: cnt <= cnt - CNT_W'(1);
                CHECK: begin
                    if (mismatch && (err_count != '1)) err_count <= err_count + ERR_CNT_W'(1);
                    if (state_nxt == DRIVE)            vec       <= vec + 10'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef CHIP7458_FAIL_CAPTURE_EN
    // Only the first mismatch of a sweep is kept; later ones leave the capture alone.
    always_ff @(posedge clk) begin
        if (!resetn || launch) begin
            fail_valid <= 1'b0;
            fail_vec   <= '0;
            fail_y     <= '0;
        end else if (mismatch && !fail_valid) begin
            fail_valid <= 1'b1;
            fail_vec   <= vec;
            fail_y     <= obs_y;
        end
    end
`else
    assign fail_valid = 1'b0;
    assign fail_vec   = '0;
    assign fail_y     = '0;
`endif

    assign {p1a, p1b, p1c, p1d, p1e, p1f, p2a, p2b, p2c, p2d} = pins;

    assign busy = (state == DRIVE) || (state == SETTLE) || (state == CHECK);
    assign done = (state == DONE);
    assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_chip_7458_tester.sv
// Bench for chip_7458_tester: behavioural chip with injectable faults and a cycle-level sweep model.
// Two instances: default parameters, and SETTLE_CYCLES=0 with a 4-bit saturating error counter.
`timescale 1ns/1ps
module tb_chip_7458_tester;

    localparam int SETTLE     = 2;
    localparam int PER_VEC    = SETTLE + 2;
    localparam int SM_PER_VEC = 2;

    logic clk = 1'b0;
    logic resetn, start, stop_on_fail;
    logic [1:0] y_m = 2'b00;
    logic [1:0] y_s = 2'b00;

    wire [9:0]  pins, pins_s;
    wire        busy, done, pass, fail_valid;
    wire [10:0] err_count;
    wire [9:0]  fail_vec;
    wire [1:0]  fail_y;
    wire        busy_s, done_s, pass_s, fail_valid_s;
    wire [3:0]  err_count_s;
    wire [9:0]  fail_vec_s;
    wire [1:0]  fail_y_s;

    always #5 clk = ~clk;

    chip_7458_tester #(.SETTLE_CYCLES(SETTLE), .ERR_CNT_W(11)) u_dut (
        .clk(clk), .resetn(resetn), .start(start), .stop_on_fail(stop_on_fail),
        .p1a(pins[9]), .p1b(pins[8]), .p1c(pins[7]), .p1d(pins[6]), .p1e(pins[5]),
        .p1f(pins[4]), .p2a(pins[3]), .p2b(pins[2]), .p2c(pins[1]), .p2d(pins[0]),
        .p1y(y_m[1]), .p2y(y_m[0]),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_valid(fail_valid), .fail_vec(fail_vec), .fail_y(fail_y)
    );

    chip_7458_tester #(.SETTLE_CYCLES(0), .ERR_CNT_W(4)) u_dut_small (
        .clk(clk), .resetn(resetn), .start(start), .stop_on_fail(stop_on_fail),
        .p1a(pins_s[9]), .p1b(pins_s[8]), .p1c(pins_s[7]), .p1d(pins_s[6]), .p1e(pins_s[5]),
        .p1f(pins_s[4]), .p2a(pins_s[3]), .p2b(pins_s[2]), .p2c(pins_s[1]), .p2d(pins_s[0]),
        .p1y(y_s[1]), .p2y(y_s[0]),
        .busy(busy_s), .done(done_s), .pass(pass_s), .err_count(err_count_s),
        .fail_valid(fail_valid_s), .fail_vec(fail_vec_s), .fail_y(fail_y_s)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Chip model: 0 ideal, 1 p2y stuck-at-0, 2 p1y inverted, 3 random per-vector flips.
    int         fault_mode = 0;
    bit         glitch_en  = 1'b1;
    logic [1:0] flip_tbl [1024];

    function automatic logic [1:0] golden(input int v);
        logic g1, g2;
        g1 = (((v >> 7) & 7) == 7) || (((v >> 4) & 7) == 7);
        g2 = (((v >> 2) & 3) == 3) || ((v & 3) == 3);
        return {g1, g2};
    endfunction

    function automatic logic [1:0] obs(input int v);
        logic [1:0] g;
        g = golden(v);
        case (fault_mode)
            1:       return {g[1], 1'b0};
            2:       return {~g[1], g[0]};
            3:       return g ^ flip_tbl[v];
            default: return g;
        endcase
    endfunction

    // Output is garbage for SETTLE cycles after the pins move; a correct sweep never samples it.
    int         age = 99;
    logic [9:0] last_pins = '0;
    always @(posedge clk) begin
        #1;
        if (pins !== last_pins) age = 0;
        else if (age < 99)      age++;
        last_pins = pins;
        y_m = (glitch_en && age < SETTLE) ? 2'($urandom) : obs(int'(pins));
        y_s = obs(int'(pins_s));
    end

    // Sweep model: cycle count since the accepted start edge plus per-vector outcome tables.
    bit         chk_en = 1'b0;
    bit         m_started = 1'b0;
    int         m_k = 0;
    int         m_nvec = 1024;
    int         m_first = -1;
    int         m_pins_before = 0;
    logic [1:0] m_obs_first = '0;
    int         m_cum [1024];

    task automatic plan_sweep();
        int cnt;
        cnt     = 0;
        m_first = -1;
        m_nvec  = 1024;
        for (int v = 0; v < 1024; v++) begin
            if (obs(v) != golden(v)) begin
                cnt++;
                if (m_first < 0) begin
                    m_first     = v;
                    m_obs_first = obs(v);
                end
            end
            m_cum[v] = cnt;
            if (stop_on_fail && m_first >= 0) begin
                m_nvec = v + 1;
                break;
            end
        end
    endtask

    function automatic int sat(input int x, input int w);
        return (x >= (1 << w) - 1) ? (1 << w) - 1 : x;
    endfunction

    always @(posedge clk) begin
        if (!resetn) begin
            m_started = 1'b0;
            m_k       = 0;
            chk_en    = 1'b1;
        end else if (m_started && m_k < m_nvec * PER_VEC) begin
            m_k++;
        end else if (start) begin
            m_pins_before = m_started ? m_nvec - 1 : 0;
            plan_sweep();
            m_started = 1'b1;
            m_k       = 0;
        end
    end

    always @(negedge clk) begin : cmp
        int  done_vecs, e, exp_pins;
        bit  exp_busy, exp_done, exp_fv;
        if (chk_en) begin
            if (!m_started) begin
                exp_busy = 1'b0; exp_done = 1'b0; exp_pins = 0; done_vecs = 0; e = 0;
            end else begin
                exp_busy  = (m_k < m_nvec * PER_VEC);
                exp_done  = !exp_busy;
                exp_pins  = (m_k == 0) ? m_pins_before : (m_k - 1) / PER_VEC;
                done_vecs = m_k / PER_VEC;
                e         = (done_vecs == 0) ? 0 : m_cum[done_vecs - 1];
            end
            exp_fv = m_started && (m_first >= 0) && (m_first < done_vecs);
            check("busy", busy, exp_busy);
            check("done", done, exp_done);
            check("pass", pass, exp_done && (e == 0));
            check("pins", pins, exp_pins);
            check("err_count", err_count, sat(e, 11));
`ifdef CHIP7458_FAIL_CAPTURE_EN
            check("fail_valid", fail_valid, exp_fv);
            check("fail_vec", fail_vec, exp_fv ? m_first : 0);
            check("fail_y", fail_y, exp_fv ? m_obs_first : 0);
`else
            check("fail_valid", fail_valid, 0);
            check("fail_vec", fail_vec, 0);
            check("fail_y", fail_y, 0);
`endif
            if (!m_started) begin
                check("s_busy_idle", busy_s, 0);
                check("s_done_idle", done_s, 0);
                check("s_err_idle", err_count_s, 0);
            end else if (m_k == m_nvec * SM_PER_VEC - 1) begin
                check("s_busy_last", busy_s, 1);
                check("s_done_last", done_s, 0);
            end else if (m_k == m_nvec * SM_PER_VEC) begin
                check("s_done", done_s, 1);
                check("s_busy", busy_s, 0);
                check("s_err", err_count_s, sat(m_cum[m_nvec - 1], 4));
                check("s_pass", pass_s, m_cum[m_nvec - 1] == 0);
                check("s_pins", pins_s, m_nvec - 1);
`ifdef CHIP7458_FAIL_CAPTURE_EN
                check("s_fail_valid", fail_valid_s, m_first >= 0);
                check("s_fail_vec", fail_vec_s, (m_first >= 0) ? m_first : 0);
`else
                check("s_fail_valid", fail_valid_s, 0);
`endif
            end
        end
    end

    // Call just after a negedge; returns edges from the start edge to done (-1 on timeout).
    task automatic run_sweep(input int hold, output int cycles);
        start  = 1'b1;
        cycles = -1;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (i == hold - 1) start = 1'b0;
            if (done === 1'b1) begin
                cycles = i;
                break;
            end
        end
        start = 1'b0;
        check("sweep_ends", cycles >= 0, 1);
    endtask

    task automatic new_flips(output int nflips, output int first);
        nflips = 0;
        first  = -1;
        for (int v = 0; v < 1024; v++) begin
            flip_tbl[v] = ($urandom_range(0, 63) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            if (flip_tbl[v] != 2'b00) begin
                nflips++;
                if (first < 0) first = v;
            end
        end
    endtask

    initial begin
        int cyc, nflips, first, hold;
        resetn = 1'b0; start = 1'b0; stop_on_fail = 1'b0;
        for (int v = 0; v < 1024; v++) flip_tbl[v] = 2'b00;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pins", pins, 0);
        check("rst_err", err_count, 0);
        resetn = 1'b1;
        @(negedge clk);

        // Ideal chip, full sweep.
        fault_mode = 0;
        run_sweep(1, cyc);
        check("t1_cycles", cyc, 4096);
        check("t1_pass", pass, 1);
        check("t1_err", err_count, 0);
        check("t1_fail_valid", fail_valid, 0);

        // p2y stuck-at-0.
        fault_mode = 1;
        run_sweep(1, cyc);
        check("t2_err", err_count, 448);
        check("t2_pass", pass, 0);
`ifdef CHIP7458_FAIL_CAPTURE_EN
        check("t2_fail_valid", fail_valid, 1);
        check("t2_fail_vec", fail_vec, 3);
        check("t2_fail_y", fail_y, 0);
`endif

        // Same fault, stop at first mismatch.
        stop_on_fail = 1'b1;
        run_sweep(1, cyc);
        check("t3_cycles", cyc, 16);
        check("t3_err", err_count, 1);
        check("t3_pins", pins, 3);
        stop_on_fail = 1'b0;

        // p1y inverted: every vector fails, small instance saturates.
        fault_mode = 2;
        run_sweep(1, cyc);
        check("t4_err", err_count, 1024);
        check("t4_s_err", err_count_s, 15);
        check("t4_s_pass", pass_s, 0);

        // Reset 100 cycles into a sweep, then a clean sweep.
        fault_mode = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (99) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check("t5_busy", busy, 0);
        check("t5_pins", pins, 0);
        check("t5_err", err_count, 0);
        check("t5_done", done, 0);
        resetn = 1'b1;
        @(negedge clk);
        run_sweep(1, cyc);
        check("t5_cycles", cyc, 4096);
        check("t5_pass", pass, 1);

        // Long start pulse gives one sweep; a second start re-runs from DONE.
        fault_mode = 3;
        new_flips(nflips, first);
        hold = $urandom_range(200, 1500);
        run_sweep(hold, cyc);
        check("t6_cycles", cyc, 4096);
        check("t6_err", err_count, nflips);
        run_sweep(1, cyc);
        check("t6_rerun_cycles", cyc, 4096);
        check("t6_rerun_err", err_count, nflips);

        // Random flips, random stop_on_fail and glitching.
        for (int r = 0; r < 2; r++) begin
            new_flips(nflips, first);
            stop_on_fail = 1'($urandom_range(0, 1));
            glitch_en    = 1'($urandom_range(0, 1));
            run_sweep(1, cyc);
            if (stop_on_fail && first >= 0) begin
                check("rnd_cycles", cyc, (first + 1) * PER_VEC);
                check("rnd_err", err_count, 1);
            end else begin
                check("rnd_cycles", cyc, 4096);
                check("rnd_err", err_count, nflips);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
